// File: rtl/mc_ctrl_pkg.sv
//==============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared state enum and encodings for the multicycle controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    s_fetch    = 4'd0,
    s_decode   = 4'd1,
    s_memadr   = 4'd2,
    s_memrd    = 4'd3,
    s_memwb    = 4'd4,
    s_memwr    = 4'd5,
    s_executer = 4'd6,
    s_executei = 4'd7,
    s_aluwb    = 4'd8,
    s_branch   = 4'd9,
    s_unknown  = 4'd10
  } state_t;

  // ALUControl command codes
  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [2:0] c_alu_and = 3'd2;
  localparam logic [2:0] c_alu_orr = 3'd3;
  localparam logic [2:0] c_alu_eor = 3'd4;

  // Funct[4:1] data-processing opcodes
  localparam logic [3:0] c_cmd_and = 4'b0000;
  localparam logic [3:0] c_cmd_eor = 4'b0001;
  localparam logic [3:0] c_cmd_sub = 4'b0010;
  localparam logic [3:0] c_cmd_add = 4'b0100;
  localparam logic [3:0] c_cmd_tst = 4'b1000;
  localparam logic [3:0] c_cmd_cmp = 4'b1010;
  localparam logic [3:0] c_cmd_orr = 4'b1100;

  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_data   = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  localparam logic [1:0] c_srcb_reg  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

  localparam logic [3:0] c_cond_eq = 4'h0;
  localparam logic [3:0] c_cond_ne = 4'h1;
  localparam logic [3:0] c_cond_cs = 4'h2;
  localparam logic [3:0] c_cond_cc = 4'h3;
  localparam logic [3:0] c_cond_mi = 4'h4;
  localparam logic [3:0] c_cond_pl = 4'h5;
  localparam logic [3:0] c_cond_vs = 4'h6;
  localparam logic [3:0] c_cond_vc = 4'h7;
  localparam logic [3:0] c_cond_hi = 4'h8;
  localparam logic [3:0] c_cond_ls = 4'h9;
  localparam logic [3:0] c_cond_ge = 4'hA;
  localparam logic [3:0] c_cond_lt = 4'hB;
  localparam logic [3:0] c_cond_gt = 4'hC;
  localparam logic [3:0] c_cond_le = 4'hD;
  localparam logic [3:0] c_cond_al = 4'hE;

endpackage

`default_nettype wire

// File: rtl/mc_condlogic.sv
//==============================================================================
// Module   : mc_condlogic
// Brief    : Flags register, ARM condition evaluation and write-enable gating.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_w,
  input  logic       i_next_pc,
  input  logic       i_branch,
  input  logic       i_reg_w,
  input  logic       i_mem_w,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_mem_write
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_ex;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b0;
    case (i_cond)
      c_cond_eq: w_cond_ex = w_z;
      c_cond_ne: w_cond_ex = ~w_z;
      c_cond_cs: w_cond_ex = w_c;
      c_cond_cc: w_cond_ex = ~w_c;
      c_cond_mi: w_cond_ex = w_n;
      c_cond_pl: w_cond_ex = ~w_n;
      c_cond_vs: w_cond_ex = w_v;
      c_cond_vc: w_cond_ex = ~w_v;
      c_cond_hi: w_cond_ex = w_c & ~w_z;
      c_cond_ls: w_cond_ex = ~w_c | w_z;
      c_cond_ge: w_cond_ex = (w_n == w_v);
      c_cond_lt: w_cond_ex = (w_n != w_v);
      c_cond_gt: w_cond_ex = ~w_z & (w_n == w_v);
      c_cond_le: w_cond_ex = w_z | (w_n != w_v);
      c_cond_al: w_cond_ex = 1'b1;
      default:   w_cond_ex = 1'b0;
    endcase
  end

  // NZ and CV halves load independently so logical ops keep the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else begin
      if (i_flag_w[1] && w_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_w[0] && w_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign o_pc_write  = i_next_pc | (i_branch & w_cond_ex);
  assign o_reg_write = i_reg_w & w_cond_ex;
  assign o_mem_write = i_mem_w & w_cond_ex;

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
//==============================================================================
// Module   : mc_controller
// Brief    : Multicycle ARM-subset control unit: main FSM and ALU decoder.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       Instr,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              ALUSrcA,
  output logic              RegWrite,
  output logic              Illegal,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl
);

  localparam bit c_ext = (ALUC_W == 3);

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused_bits;

  assign w_cond        = Instr[19:16];
  assign w_op          = Instr[15:14];
  assign w_funct       = Instr[13:8];
  assign w_unused_bits = ^Instr[7:0];

  state_t r_state, w_next;

  logic       w_next_pc, w_branch, w_reg_w, w_mem_w, w_alu_op;
  logic       w_irwrite, w_adrsrc, w_alusrca, w_illegal;
  logic [1:0] w_resultsrc, w_alusrcb;

  logic [ALUC_W-1:0] w_cmd_code;
  logic              w_cmd_ok, w_cmd_cv, w_no_write;
  logic [1:0]        w_flag_w;

  // Command decode depends only on Funct so NoWrite stays valid in ALUWB.
  always_comb begin
    w_cmd_code = '0;
    w_cmd_ok   = 1'b0;
    w_cmd_cv   = 1'b0;
    w_no_write = 1'b1;
    case (w_funct[4:1])
      c_cmd_add: begin
        w_cmd_code = ALUC_W'(c_alu_add); w_cmd_ok = 1'b1; w_cmd_cv = 1'b1; w_no_write = 1'b0;
      end
      c_cmd_sub: begin
        w_cmd_code = ALUC_W'(c_alu_sub); w_cmd_ok = 1'b1; w_cmd_cv = 1'b1; w_no_write = 1'b0;
      end
      c_cmd_and: begin
        w_cmd_code = ALUC_W'(c_alu_and); w_cmd_ok = 1'b1; w_no_write = 1'b0;
      end
      c_cmd_orr: begin
        w_cmd_code = ALUC_W'(c_alu_orr); w_cmd_ok = 1'b1; w_no_write = 1'b0;
      end
      c_cmd_eor: if (c_ext) begin
        w_cmd_code = ALUC_W'(c_alu_eor); w_cmd_ok = 1'b1; w_no_write = 1'b0;
      end
      c_cmd_cmp: if (c_ext) begin
        w_cmd_code = ALUC_W'(c_alu_sub); w_cmd_ok = 1'b1; w_cmd_cv = 1'b1;
      end
      c_cmd_tst: if (c_ext) begin
        w_cmd_code = ALUC_W'(c_alu_and); w_cmd_ok = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl  = w_alu_op ? w_cmd_code : '0;
  assign w_flag_w[1] = w_funct[0] & w_alu_op & w_cmd_ok;
  assign w_flag_w[0] = w_funct[0] & w_alu_op & w_cmd_cv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= s_fetch;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = s_fetch;
    w_next_pc   = 1'b0;
    w_branch    = 1'b0;
    w_reg_w     = 1'b0;
    w_mem_w     = 1'b0;
    w_alu_op    = 1'b0;
    w_irwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 1'b0;
    w_illegal   = 1'b0;
    w_resultsrc = c_res_aluout;
    w_alusrcb   = c_srcb_reg;
    case (r_state)
      s_fetch: begin
        w_irwrite   = 1'b1;
        w_alusrca   = 1'b1;
        w_alusrcb   = c_srcb_four;
        w_resultsrc = c_res_alu;
        w_next_pc   = 1'b1;
        w_next      = s_decode;
      end
      s_decode: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = c_srcb_four;
        w_resultsrc = c_res_alu;
        case (w_op)
          2'b00:   w_next = w_funct[5] ? s_executei : s_executer;
          2'b01:   w_next = s_memadr;
          2'b10:   w_next = s_branch;
          default: w_next = s_unknown;
        endcase
      end
      s_memadr: begin
        w_alusrcb = c_srcb_imm;
        w_next    = w_funct[0] ? s_memrd : s_memwr;
      end
      s_memrd: begin
        w_adrsrc = 1'b1;
        w_next   = s_memwb;
      end
      s_memwb: begin
        w_resultsrc = c_res_data;
        w_reg_w     = 1'b1;
      end
      s_memwr: begin
        w_adrsrc = 1'b1;
        w_mem_w  = 1'b1;
      end
      s_executer: begin
        w_alu_op = 1'b1;
        w_next   = s_aluwb;
      end
      s_executei: begin
        w_alusrcb = c_srcb_imm;
        w_alu_op  = 1'b1;
        w_next    = s_aluwb;
      end
      s_aluwb: begin
        w_reg_w = ~w_no_write;
      end
      s_branch: begin
        w_alusrcb   = c_srcb_imm;
        w_resultsrc = c_res_alu;
        w_branch    = 1'b1;
      end
      s_unknown: begin
        w_illegal = 1'b1;
      end
      default: w_next = s_fetch;
    endcase
  end

  assign IRWrite   = w_irwrite;
  assign AdrSrc    = w_adrsrc;
  assign ALUSrcA   = w_alusrca;
  assign ALUSrcB   = w_alusrcb;
  assign ResultSrc = w_resultsrc;
  assign Illegal   = w_illegal;
  assign ImmSrc    = w_op;
  assign RegSrc    = {w_op == 2'b01, w_op == 2'b10};

  mc_condlogic u_cond (
    .clk         (clk),
    .rst_n       (reset),
    .i_cond      (w_cond),
    .i_alu_flags (ALUFlags),
    .i_flag_w    (w_flag_w),
    .i_next_pc   (w_next_pc),
    .i_branch    (w_branch),
    .i_reg_w     (w_reg_w),
    .i_mem_w     (w_mem_w),
    .o_pc_write  (PCWrite),
    .o_reg_write (RegWrite),
    .o_mem_write (MemWrite)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
//==============================================================================
// Module   : tb_mc_controller
// Brief    : Checks both ALUControl widths against an instruction-level model.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mc_controller;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3,
                 PH_MEMWB = 4, PH_MEMWR = 5, PH_EXECR = 6, PH_EXECI = 7,
                 PH_ALUWB = 8, PH_BRANCH = 9, PH_UNKNOWN = 10;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;

  logic       pcw2, adr2, mw2, irw2, sa2, rw2, il2;
  logic [1:0] res2, sb2, imm2, rs2, aluc2;
  logic       pcw3, adr3, mw3, irw3, sa3, rw3, il3;
  logic [1:0] res3, sb3, imm3, rs3;
  logic [2:0] aluc3;

  logic [17:0] obs2, obs3;
  assign obs2 = {pcw2, adr2, mw2, irw2, sa2, rw2, il2, res2, sb2, imm2, rs2, 1'b0, aluc2};
  assign obs3 = {pcw3, adr3, mw3, irw3, sa3, rw3, il3, res3, sb3, imm3, rs3, aluc3};

  int checks   = 0;
  int failures = 0;
  logic [3:0] mfl2, mfl3;

  mc_controller #(.ALUC_W(2)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .ALUSrcA(sa2),
    .RegWrite(rw2), .Illegal(il2), .ResultSrc(res2), .ALUSrcB(sb2), .ImmSrc(imm2),
    .RegSrc(rs2), .ALUControl(aluc2)
  );

  mc_controller #(.ALUC_W(3)) dut3 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw3), .AdrSrc(adr3), .MemWrite(mw3), .IRWrite(irw3), .ALUSrcA(sa3),
    .RegWrite(rw3), .Illegal(il3), .ResultSrc(res3), .ALUSrcB(sb3), .ImmSrc(imm3),
    .RegSrc(rs3), .ALUControl(aluc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] fl);
    bit n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {supported, writes_cv, no_write, alu_code[2:0]}.
  function automatic logic [5:0] cmd_info(input logic [5:0] f, input bit ext);
    case (f[4:1])
      4'b0100: return 6'b110_000;
      4'b0010: return 6'b110_001;
      4'b0000: return 6'b100_010;
      4'b1100: return 6'b100_011;
      4'b0001: return ext ? 6'b100_100 : 6'b001_000;
      4'b1010: return ext ? 6'b111_001 : 6'b001_000;
      4'b1000: return ext ? 6'b101_010 : 6'b001_000;
      default: return 6'b001_000;
    endcase
  endfunction

  function automatic logic [17:0] exp_row(input int ph, input logic [19:0] ins,
                                          input logic [3:0] fl, input bit ext);
    logic [1:0] op, res, sb;
    logic [2:0] alu;
    logic [5:0] ci;
    bit ce, pcw, adr, mw, irw, sa, rw, il;
    op = ins[15:14];
    ce = cond_ok(ins[19:16], fl);
    ci = cmd_info(ins[13:8], ext);
    {pcw, adr, mw, irw, sa, rw, il} = 7'b0;
    res = 2'b00; sb = 2'b00; alu = 3'b000;
    case (ph)
      PH_FETCH:   begin pcw = 1; irw = 1; sa = 1; sb = 2'b10; res = 2'b10; end
      PH_DECODE:  begin sa = 1; sb = 2'b10; res = 2'b10; end
      PH_MEMADR:  sb = 2'b01;
      PH_MEMRD:   adr = 1;
      PH_MEMWB:   begin res = 2'b01; rw = ce; end
      PH_MEMWR:   begin adr = 1; mw = ce; end
      PH_EXECR:   alu = ci[2:0];
      PH_EXECI:   begin sb = 2'b01; alu = ci[2:0]; end
      PH_ALUWB:   rw = !ci[3] && ce;
      PH_BRANCH:  begin sb = 2'b01; res = 2'b10; pcw = ce; end
      PH_UNKNOWN: il = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, sa, rw, il, res, sb, op, op == 2'b01, op == 2'b10, alu};
  endfunction

  function automatic logic [3:0] next_flags(input logic [19:0] ins, input logic [3:0] af,
                                            input logic [3:0] fl, input bit ext);
    logic [5:0] ci;
    logic [3:0] nf;
    ci = cmd_info(ins[13:8], ext);
    nf = fl;
    if (ins[8] && ci[5] && cond_ok(ins[19:16], fl)) begin
      nf[3:2] = af[3:2];
      if (ci[4]) nf[1:0] = af[1:0];
    end
    return nf;
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_flags3"}, {14'b0, dut3.u_cond.r_flags}, {14'b0, mfl3});
    check({tag, "_flags2"}, {14'b0, dut2.u_cond.r_flags}, {14'b0, mfl2});
  endtask

  // Samples mid-cycle; the model flags advance when an execute phase ends.
  task automatic check_phase(input int ph, input logic [19:0] ins, input string tag);
    @(negedge clk);
    check({tag, "_w3"}, obs3, exp_row(ph, ins, mfl3, 1'b1));
    check({tag, "_w2"}, obs2, exp_row(ph, ins, mfl2, 1'b0));
    if (ph == PH_EXECR || ph == PH_EXECI) begin
      mfl3 = next_flags(ins, ALUFlags, mfl3, 1'b1);
      mfl2 = next_flags(ins, ALUFlags, mfl2, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input string name);
    int ph[$];
    logic [5:0] f;
    Instr    = ins;
    ALUFlags = af;
    f = ins[13:8];
    ph.push_back(PH_FETCH);
    ph.push_back(PH_DECODE);
    case (ins[15:14])
      2'b01: begin
        ph.push_back(PH_MEMADR);
        if (f[0]) begin ph.push_back(PH_MEMRD); ph.push_back(PH_MEMWB); end
        else ph.push_back(PH_MEMWR);
      end
      2'b00: begin ph.push_back(f[5] ? PH_EXECI : PH_EXECR); ph.push_back(PH_ALUWB); end
      2'b10: ph.push_back(PH_BRANCH);
      default: ph.push_back(PH_UNKNOWN);
    endcase
    foreach (ph[i]) begin
      check_phase(ph[i], ins, $sformatf("%s_c%0d", name, i));
      @(posedge clk);
      #1;
    end
    check_flags(name);
  endtask

  task automatic pulse_reset(input string name);
    reset = 1'b0;
    #1;
    mfl2 = 4'b0;
    mfl3 = 4'b0;
    check({name, "_w3"}, obs3, exp_row(PH_FETCH, Instr, 4'b0, 1'b1));
    check({name, "_w2"}, obs2, exp_row(PH_FETCH, Instr, 4'b0, 1'b0));
    check_flags(name);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 20'hE0812;
    ALUFlags = 4'b0000;
    mfl2     = 4'b0;
    mfl3     = 4'b0;
    #3;
    check("reset_w3", obs3, 18'b1_0_0_1_1_0_0_10_10_00_00_000);
    check("reset_w2", obs2, 18'b1_0_0_1_1_0_0_10_10_00_00_000);
    check_flags("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold_w3", obs3, 18'b1_0_0_1_1_0_0_10_10_00_00_000);
    reset = 1'b1;

    run_instr(20'hE0812, 4'b0000, "add");
    run_instr(20'hE5912, 4'b0000, "ldr");
    run_instr(20'hE0512, 4'b0100, "subs_z");
    run_instr(20'h0A000, 4'b0000, "beq_taken");
    run_instr(20'hE0512, 4'b0000, "subs_nz");
    run_instr(20'h0A000, 4'b0100, "beq_not");

    pulse_reset("pre_cmp");
    run_instr(20'hE1500, 4'b0110, "cmp");
    check("cmp_flags_ext", {14'b0, dut3.u_cond.r_flags}, 18'h00006);
    check("cmp_flags_base", {14'b0, dut2.u_cond.r_flags}, 18'h00000);

    // Store interrupted by reset during MEMWR.
    Instr    = 20'hE5812;
    ALUFlags = 4'b1001;
    check_phase(PH_FETCH, Instr, "str_c0");  @(posedge clk); #1;
    check_phase(PH_DECODE, Instr, "str_c1"); @(posedge clk); #1;
    check_phase(PH_MEMADR, Instr, "str_c2"); @(posedge clk); #1;
    check_phase(PH_MEMWR, Instr, "str_c3");
    reset = 1'b0;
    #1;
    check("str_rst_memwrite3", {17'b0, mw3}, 18'b0);
    check("str_rst_memwrite2", {17'b0, mw2}, 18'b0);
    mfl2 = 4'b0;
    mfl3 = 4'b0;
    check("str_rst_w3", obs3, exp_row(PH_FETCH, Instr, 4'b0, 1'b1));
    check_flags("str_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(20'hE0812, 4'b0000, "after_rst");

    run_instr(20'hEC000, 4'b1111, "undef");
    run_instr(20'hE0812, 4'b0000, "after_undef");

    for (int k = 0; k < 300; k++) begin
      run_instr(20'($urandom), 4'($urandom), $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
